game_event_gen: RTL and testbench
=================================

# game_event_gen

Producer side of the screen-mode controller's `start`/`gameover` inputs.
- Turns the raw active-low start pushbutton into a single-cycle `start` pulse, issued only on the Home screen.
- Turns spawn-collision reports from the playfield logic into a held `gameover` level, asserted only on the Game screen.
- Consumes the controller's `mode` output, closing the loop between game logic and screen FSM.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000, cycles `key_s` must differ from the debounced value before it flips (10 ms at 50 MHz); minimum 2.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- Clk  in  1  system clock
- Resetn  in  1  synchronous, active-low reset
- key_start_n  in  1  raw asynchronous pushbutton, 0 = pressed
- mode  in  2  screen mode: 2'b10 Home, 2'b01 Game, 2'b00 End, 2'b11 invalid
- spawn_req  in  1  one-cycle pulse, new piece spawning
- spawn_collide  in  1  qualified by spawn_req; 1 = spawn cells overlap the occupied board
- lock_top  in  1  only with TETRIS_TOPOUT_EN; one-cycle pulse, a piece locked above the visible rows
- start  out  1  one-cycle pulse to the screen FSM
- gameover  out  1  level to the screen FSM

## Operation
- Synchronizer: two flops on `key_start_n`, inverted; the result is `key_s` (1 = pressed).
- Debounce, on each edge:
  - `key_s == deb`: `cnt <= 0`.
  - otherwise, `cnt == DEBOUNCE_CYCLES-1`: `deb <= key_s`, `cnt <= 0`.
  - otherwise: `cnt <= cnt+1`.
  - Glitches shorter than DEBOUNCE_CYCLES are rejected.
- `press` = `deb & ~deb_d` (combinational; `deb_d` is `deb` delayed one cycle).
- Start FSM (Moore; `start = (state == ST_FIRE)`):
  - ST_WAIT_REL -> ST_ARMED when `deb == 0`.
  - ST_ARMED -> ST_FIRE on `press` with `mode == 2'b10`.
  - ST_ARMED -> ST_WAIT_REL on `press` with any other mode; no pulse.
  - ST_FIRE -> ST_WAIT_REL unconditionally.
  - Result: exactly one pulse per physical press; a key held through reset never starts a game.
- Gameover FSM (Moore; `gameover = (gstate == G_HOLD)`):
  - G_IDLE -> G_HOLD when `mode == 2'b01 && spawn_req && spawn_collide`.
  - G_HOLD -> G_IDLE when `mode != 2'b01`.
  - `spawn_collide` is ignored without `spawn_req`. Spawn events outside Game mode are ignored.
- `mode == 2'b11`: counts as neither Home nor Game.

## Timing
- Reset (Resetn = 0 at an edge) sets:
  - both synchronizer flops, `deb`, `deb_d` = pressed (1)
  - `cnt` = 0
  - state = ST_WAIT_REL, gstate = G_IDLE
  - `start` = 0, `gameover` = 0
- Key press latency:
  - `key_start_n` low before edge 0 makes `key_s` = 1 after edge 1.
  - `deb` flips at edge 1+DEBOUNCE_CYCLES.
  - `start` is high for exactly the cycle after edge 2+DEBOUNCE_CYCLES.
- Gameover latency: `spawn_req` and `spawn_collide` sampled at edge N drive `gameover` high after edge N. It stays high through the cycle after `mode` first reads != Game.
- Simultaneous `press` and mode change: the mode value sampled at the same edge decides.
- Reset mid-operation: outputs are 0 from the next cycle. A pending debounce count is discarded.

## Configuration
- Macro TETRIS_TOPOUT_EN.
- Defined: port `lock_top` exists. G_IDLE -> G_HOLD also when `mode == 2'b01 && lock_top`. This rule ORs with the spawn rule.
- Undefined: no `lock_top` port; gameover comes only from spawn collision.

## Structure
- Shared package `tetris_pkg` holds:
  - mode constants MODE_HOME = 2'b10, MODE_GAME = 2'b01, MODE_END = 2'b00
  - start-FSM state encodings
  - gameover-FSM state encodings
- Sub-module `key_debounce` holds the synchronizer, counter, `deb` and `deb_d`. Ports: Clk, Resetn, key_n, deb, press. Parameters DEBOUNCE_CYCLES, CNT_W.

## Test plan
Benches use DEBOUNCE_CYCLES = 4.
- Reset, key released, mode = 10; key pressed before edge 0 and held → `start` high only in the cycle after edge 6; no second pulse while held for 50 cycles.
- Key held low through reset release → no `start` until the key is released for ≥4 cycles and pressed again.
- Key glitches of 1–3 cycles, mode = 10 → `deb` never flips; `start` stays 0.
- Mode = 01: `spawn_req` = 1 with `spawn_collide` = 0 → `gameover` 0. Then both = 1 at edge N → `gameover` 1 from N+1. Mode changed to 00 → `gameover` drops the cycle after mode reads 00.
- Press while mode = 01 or 00 → no `start`; re-arms after release.
- TETRIS_TOPOUT_EN defined, mode = 01, `lock_top` pulse → `gameover` next cycle. Same pulse with mode = 10 → ignored.

Source files
------------

// File: rtl/tetris_pkg.sv
// tetris_pkg: shared screen-mode constants and FSM state encodings for the
// game-event producer and the screen-mode controller.
package tetris_pkg;

  // Screen modes driven by the screen-mode controller (2'b11 is invalid)
  localparam logic [1:0] MODE_HOME = 2'b10;
  localparam logic [1:0] MODE_GAME = 2'b01;
  localparam logic [1:0] MODE_END  = 2'b00;

  // Start-pulse FSM
  localparam logic [1:0] ST_WAIT_REL = 2'd0;
  localparam logic [1:0] ST_ARMED    = 2'd1;
  localparam logic [1:0] ST_FIRE     = 2'd2;

  // Gameover FSM
  localparam logic [0:0] G_IDLE = 1'b0;
  localparam logic [0:0] G_HOLD = 1'b1;

endpackage

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchronizer plus counter debouncer for an
// active-low pushbutton. deb is 1 while pressed; press is the rising edge
// of deb. Everything resets to "pressed" so a key held through reset never
// looks like a fresh press.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic Clk,
  input  logic Resetn,
  input  logic key_n,
  output logic deb,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             key_s;
  logic             deb_d;
  logic [CNT_W-1:0] cnt;

  // Synchronize the raw button and invert it so 1 = pressed
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      sync1 <= 1'b1;
      key_s <= 1'b1;
    end else begin
      sync1 <= ~key_n;
      key_s <= sync1;
    end
  end

  // Flip deb only after key_s has disagreed with it for DEBOUNCE_CYCLES edges
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      cnt   <= '0;
      deb   <= 1'b1;
      deb_d <= 1'b1;
    end else begin
      deb_d <= deb;
      if (key_s == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= key_s;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = deb & ~deb_d;

endmodule

// File: rtl/game_event_gen.sv
// game_event_gen: produces the screen FSM's start pulse (debounced button,
// Home screen only) and gameover level (spawn collision, Game screen only).
// Optional feature macro TETRIS_TOPOUT_EN adds the lock_top input, which also
// raises gameover when a piece locks above the visible rows.
module game_event_gen
  import tetris_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       Clk,
  input  logic       Resetn,
  input  logic       key_start_n,
  input  logic [1:0] mode,
  input  logic       spawn_req,
  input  logic       spawn_collide,
`ifdef TETRIS_TOPOUT_EN
  input  logic       lock_top,
`endif
  output logic       start,
  output logic       gameover
);

  logic       deb;
  logic       press;
  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [0:0] gstate;
  logic       over_evt;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_deb (
    .Clk   (Clk),
    .Resetn(Resetn),
    .key_n (key_start_n),
    .deb   (deb),
    .press (press)
  );

  // Start FSM next state: must see the key released before a press counts,
  // and a press on any screen but Home is consumed without a pulse
  always_comb begin
    state_nxt = state;
    case (state)
      ST_WAIT_REL: if (!deb) state_nxt = ST_ARMED;
      ST_ARMED:    if (press) state_nxt = (mode == MODE_HOME) ? ST_FIRE : ST_WAIT_REL;
      ST_FIRE:     state_nxt = ST_WAIT_REL;
      default:     state_nxt = ST_WAIT_REL;
    endcase
  end

  // Start FSM state register
  always_ff @(posedge Clk) begin
    if (!Resetn) state <= ST_WAIT_REL;
    else         state <= state_nxt;
  end

  assign start = (state == ST_FIRE);

`ifdef TETRIS_TOPOUT_EN
  assign over_evt = (spawn_req & spawn_collide) | lock_top;
`else
  assign over_evt = spawn_req & spawn_collide;
`endif

  // Gameover FSM: latch a game-ending event while in Game, hold until the
  // controller leaves the Game screen
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      gstate <= G_IDLE;
    end else begin
      case (gstate)
        G_IDLE:  if (mode == MODE_GAME && over_evt) gstate <= G_HOLD;
        default: if (mode != MODE_GAME) gstate <= G_IDLE;
      endcase
    end
  end

  assign gameover = (gstate == G_HOLD);

endmodule

// File: tb/tb_game_event_gen.sv
// tb_game_event_gen: directed table + hand sequences + randomized run checked
// against a behavioural model of the start/gameover rules.
module tb_game_event_gen;

  localparam int D = 4;
`ifdef TETRIS_TOPOUT_EN
  localparam bit TOPOUT = 1'b1;
`else
  localparam bit TOPOUT = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Resetn = 1'b0;
  logic       key_start_n = 1'b1;
  logic [1:0] mode = 2'b10;
  logic       spawn_req = 1'b0;
  logic       spawn_collide = 1'b0;
  logic       lock_top = 1'b0;
  logic       start;
  logic       gameover;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  game_event_gen #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .Clk          (Clk),
    .Resetn       (Resetn),
    .key_start_n  (key_start_n),
    .mode         (mode),
    .spawn_req    (spawn_req),
    .spawn_collide(spawn_collide),
`ifdef TETRIS_TOPOUT_EN
    .lock_top     (lock_top),
`endif
    .start        (start),
    .gameover     (gameover)
  );

  // Behavioural model state
  bit m_s1 = 1, m_ks = 1, m_deb = 1, m_debd = 1;
  bit m_armed = 0, m_start = 0, m_go = 0;
  bit disagree[$];   // one entry per consecutive edge where key_s != deb

  task automatic model_step();
    bit press, n_deb, ev;
    if (!Resetn) begin
      m_s1 = 1; m_ks = 1; m_deb = 1; m_debd = 1;
      m_armed = 0; m_start = 0; m_go = 0;
      disagree.delete();
      return;
    end
    press = m_deb && !m_debd;
    ev    = (spawn_req && spawn_collide) || (TOPOUT && lock_top);
    // one pulse per press, only if the key was seen released first and we are Home
    m_start = m_armed && press && (mode == 2'b10);
    if (press)       m_armed = 0;
    else if (!m_deb) m_armed = 1;
    m_go = (mode == 2'b01) && (m_go || ev);
    n_deb = m_deb;
    if (m_ks == m_deb) disagree.delete();
    else begin
      disagree.push_back(1'b1);
      if (disagree.size() == D) begin
        n_deb = m_ks;
        disagree.delete();
      end
    end
    m_debd = m_deb;
    m_deb  = n_deb;
    m_ks   = m_s1;
    m_s1   = !key_start_n;
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
    end
  endtask

  // One clock: model advances on the edge, outputs compared on the falling edge
  task automatic tick();
    @(posedge Clk);
    model_step();
    @(negedge Clk);
    chk("model_start", start, m_start);
    chk("model_gameover", gameover, m_go);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Press and hold for n edges; start expected only after edge `fire_at` (-1 = never)
  task automatic press_hold(input string nm, input int n, input int fire_at);
    key_start_n = 1'b0;
    for (int k = 0; k < n; k++) begin
      tick();
      chk(nm, start, (k == fire_at));
    end
    key_start_n = 1'b1;
    ticks(10);
  endtask

  typedef struct {
    logic [1:0] mode;
    logic       req;
    logic       col;
    logic       exp_go;
  } vec_t;

  vec_t tv[$];
  int   hold;

  initial begin
    tv.push_back('{2'b01, 1'b1, 1'b0, 1'b0});
    tv.push_back('{2'b01, 1'b0, 1'b1, 1'b0});
    tv.push_back('{2'b01, 1'b1, 1'b1, 1'b1});
    tv.push_back('{2'b01, 1'b0, 1'b0, 1'b1});
    tv.push_back('{2'b01, 1'b1, 1'b0, 1'b1});
    tv.push_back('{2'b00, 1'b0, 1'b0, 1'b0});
    tv.push_back('{2'b00, 1'b1, 1'b1, 1'b0});
    tv.push_back('{2'b10, 1'b1, 1'b1, 1'b0});
    tv.push_back('{2'b11, 1'b1, 1'b1, 1'b0});
    tv.push_back('{2'b01, 1'b0, 1'b1, 1'b0});
    tv.push_back('{2'b01, 1'b1, 1'b1, 1'b1});
    tv.push_back('{2'b11, 1'b0, 1'b0, 1'b0});
    tv.push_back('{2'b01, 1'b0, 1'b0, 1'b0});

    // Reset state
    @(negedge Clk);
    ticks(2);
    chk("reset_start", start, 1'b0);
    chk("reset_gameover", gameover, 1'b0);

    // Released key arms after reset, press fires once after edge 6
    Resetn = 1'b1;
    ticks(10);
    press_hold("press_latency", 56, 6);

    // Key held through reset never starts; release then press does
    Resetn = 1'b0;
    key_start_n = 1'b0;
    ticks(2);
    Resetn = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      chk("held_through_reset", start, 1'b0);
    end
    key_start_n = 1'b1;
    ticks(10);
    press_hold("repress_after_reset", 16, 6);

    // Glitches of 1..3 cycles are rejected
    for (int g = 1; g <= 3; g++) begin
      key_start_n = 1'b0;
      for (int k = 0; k < g; k++) tick();
      key_start_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
        tick();
        chk("glitch_start", start, 1'b0);
        chk("glitch_deb", dut.u_deb.deb, 1'b0);
      end
    end

    // Presses outside Home are consumed, then the button re-arms
    mode = 2'b01; press_hold("press_in_game", 16, -1);
    mode = 2'b00; press_hold("press_in_end", 16, -1);
    mode = 2'b11; press_hold("press_in_invalid", 16, -1);
    mode = 2'b10; press_hold("rearm_home", 16, 6);

    // Gameover table
    foreach (tv[i]) begin
      mode = tv[i].mode;
      spawn_req = tv[i].req;
      spawn_collide = tv[i].col;
      tick();
      chk($sformatf("gameover_vec%0d", i), gameover, tv[i].exp_go);
      chk("gameover_vec_start", start, 1'b0);
    end
    spawn_req = 1'b0;
    spawn_collide = 1'b0;

`ifdef TETRIS_TOPOUT_EN
    mode = 2'b01; lock_top = 1'b1; tick();
    chk("topout_game", gameover, 1'b1);
    mode = 2'b00; lock_top = 1'b0; tick();
    chk("topout_clear", gameover, 1'b0);
    mode = 2'b10; lock_top = 1'b1; tick();
    chk("topout_home_ignored", gameover, 1'b0);
    lock_top = 1'b0; tick();
    chk("topout_home_after", gameover, 1'b0);
`endif

    // Randomized run against the model
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        key_start_n = 1'($urandom);
        hold = $urandom_range(1, 12);
      end
      hold--;
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom);
      spawn_req     = ($urandom_range(0, 3) == 0);
      spawn_collide = 1'($urandom);
      lock_top      = ($urandom_range(0, 15) == 0);
      Resetn        = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
